// File: rtl/channel_framer_if.sv
// Sample-stream bundle for channel_framer: sparse desired-channel input side,
// dense framed output side and the sticky error flag.
interface channel_framer_if #(
    parameter int unsigned WDTH  = 32,
    parameter int unsigned MWDTH = 1
);
    logic [WDTH-1:0]  in_data;
    logic             in_nd;
    logic [MWDTH-1:0] in_m;
    logic             in_first;
    logic [WDTH-1:0]  out_data;
    logic             out_nd;
    logic [MWDTH-1:0] out_m;
    logic             out_first;
    logic             error;

    modport master (
        output in_data, in_nd, in_m, in_first,
        input  out_data, out_nd, out_m, out_first, error
    );

    modport slave (
        input  in_data, in_nd, in_m, in_first,
        output out_data, out_nd, out_m, out_first, error
    );
endinterface

// File: rtl/channel_framer.sv
// Packs a sparse desired-channel stream into dense N-channel frames via ping-pong buffers.
// Optional define CHANNEL_FRAMER_RESYNC_EN: misaligned input restarts framing instead of only flagging.
module channel_framer #(
    parameter int unsigned N       = 8,
    parameter int unsigned LOGN    = 3,
    parameter int unsigned WDTH    = 32,
    parameter int unsigned MWDTH   = 1,
    parameter logic [N-1:0] DESIRED = {N{1'b1}}
) (
    input  logic            clk,
    input  logic            rst,
    channel_framer_if.slave fr
);
    localparam logic [0:0] WR_HUNT = 1'b0;
    localparam logic [0:0] WR_FILL = 1'b1;
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_EMIT = 1'b1;

    function automatic logic [LOGN-1:0] lowest_des();
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) if (DESIRED[i]) r = LOGN'(i);
        return r;
    endfunction

    function automatic logic [LOGN-1:0] highest_des();
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (DESIRED[i]) r = LOGN'(i);
        return r;
    endfunction

    // Lowest desired channel strictly above c.
    function automatic logic [LOGN-1:0] next_des(input logic [LOGN-1:0] c);
        logic [LOGN-1:0] r;
        r = c;
        for (int i = N - 1; i >= 0; i--)
            if (DESIRED[i] && (i > int'(c))) r = LOGN'(i);
        return r;
    endfunction

    localparam logic [LOGN-1:0] LO = lowest_des();
    localparam logic [LOGN-1:0] HI = highest_des();

    logic [WDTH-1:0]  mem_d [2][N];
    logic [MWDTH-1:0] mem_m [2][N];

    logic [0:0]       wr_state_q, wr_state_d, rd_state_q, rd_state_d;
    logic             wsel_q, wsel_d, rsel_q, rsel_d;
    logic [LOGN-1:0]  wch_q, wch_d, rch_q, rch_d;
    logic [1:0]       full_q, full_d;
    logic             err_q, err_d;
    logic [WDTH-1:0]  out_data_q, out_data_d;
    logic [MWDTH-1:0] out_m_q, out_m_d;
    logic             out_nd_q, out_nd_d, out_first_q, out_first_d;

    logic             wr_en, rel_c, blocked, at_lo, rd_go;
    logic [LOGN-1:0]  wr_ch, rd_ch;

    // Next-state logic for both the write framer and the read emitter.
    always_comb begin
        wr_state_d  = wr_state_q;
        rd_state_d  = rd_state_q;
        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        wch_d       = wch_q;
        rch_d       = rch_q;
        full_d      = full_q;
        err_d       = err_q;
        out_data_d  = '0;
        out_m_d     = '0;
        out_nd_d    = 1'b0;
        out_first_d = 1'b0;
        wr_en       = 1'b0;
        wr_ch       = wch_q;
        rel_c       = 1'b0;
        blocked     = 1'b0;
        at_lo       = (wch_q == LO);
        rd_ch       = (rd_state_q == RD_EMIT) ? rch_q : '0;
        rd_go       = (rd_state_q == RD_EMIT) || full_q[rsel_q];

        // Idle reader starts on the same edge a buffer becomes visible as full.
        if (rd_go) begin
            out_nd_d    = 1'b1;
            out_first_d = (rd_ch == '0);
            out_data_d  = DESIRED[rd_ch] ? mem_d[rsel_q][rd_ch] : '0;
            out_m_d     = DESIRED[rd_ch] ? mem_m[rsel_q][rd_ch] : '0;
            if (rd_ch == LOGN'(N - 1)) begin
                rel_c          = 1'b1;
                full_d[rsel_q] = 1'b0;
                rsel_d         = ~rsel_q;
                rch_d          = '0;
                rd_state_d     = full_q[~rsel_q] ? RD_EMIT : RD_IDLE;
            end else begin
                rch_d      = rd_ch + LOGN'(1);
                rd_state_d = RD_EMIT;
            end
        end

        // A buffer released on this edge may be refilled on the same edge.
        if (fr.in_nd) begin
            blocked = full_q[wsel_q] && !(rel_c && (rsel_q == wsel_q));
            if (wr_state_q == WR_HUNT) begin
                if (fr.in_first) begin
                    if (blocked) err_d = 1'b1;
                    else begin
                        wr_en = 1'b1;
                        wr_ch = LO;
                    end
                end
            end else if (blocked) begin
                err_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (fr.in_first && !at_lo) begin
                    err_d = 1'b1;
`ifdef CHANNEL_FRAMER_RESYNC_EN
                    wr_ch = LO;
`endif
                end else if (!fr.in_first && at_lo) begin
                    err_d = 1'b1;
`ifdef CHANNEL_FRAMER_RESYNC_EN
                    wr_en      = 1'b0;
                    wr_state_d = WR_HUNT;
                    wch_d      = LO;
`endif
                end
            end
            if (wr_en) begin
                wr_state_d = WR_FILL;
                if (wr_ch == HI) begin
                    full_d[wsel_q] = 1'b1;
                    wsel_d         = ~wsel_q;
                    wch_d          = LO;
                end else begin
                    wch_d = next_des(wr_ch);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q  <= WR_HUNT;
            rd_state_q  <= RD_IDLE;
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            wch_q       <= LO;
            rch_q       <= '0;
            full_q      <= '0;
            err_q       <= 1'b0;
            out_data_q  <= '0;
            out_m_q     <= '0;
            out_nd_q    <= 1'b0;
            out_first_q <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            wch_q       <= wch_d;
            rch_q       <= rch_d;
            full_q      <= full_d;
            err_q       <= err_d;
            out_data_q  <= out_data_d;
            out_m_q     <= out_m_d;
            out_nd_q    <= out_nd_d;
            out_first_q <= out_first_d;
        end
    end

    // Sample storage; undesired entries are masked on read, so no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_d[wsel_q][wr_ch] <= fr.in_data;
            mem_m[wsel_q][wr_ch] <= fr.in_m;
        end
    end

    assign fr.out_data  = out_data_q;
    assign fr.out_m     = out_m_q;
    assign fr.out_nd    = out_nd_q;
    assign fr.out_first = out_first_q;
    assign fr.error     = err_q;
endmodule

// File: tb/tb_channel_framer.sv
// Scoreboard bench: two framers (full mask and sparse mask) fed identical stimulus,
// each checked against a frame-level reference model with expected output cycle stamps.
module tb_channel_framer;
    localparam logic [7:0] DES0 = 8'hFF;
    localparam logic [7:0] DES1 = 8'b0010_0110;

    typedef struct packed {
        int          at;
        logic [31:0] d;
        logic        m;
        logic        f;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_t = 0;

    channel_framer_if bus0 ();
    channel_framer_if bus1 ();

    channel_framer #(.DESIRED(DES0)) u_full   (.clk(clk), .rst(rst), .fr(bus0));
    channel_framer #(.DESIRED(DES1)) u_sparse (.clk(clk), .rst(rst), .fr(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        q0[$];
    exp_t        q1[$];
    bit          hunting [2];
    int          kpos    [2];
    bit          err_exp [2];
    int          rel_a   [2];
    int          rel_b   [2];
    logic [31:0] fd      [2][8];
    logic        fm      [2][8];

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    function automatic logic [7:0] des_of(input int idx);
        return (idx == 0) ? DES0 : DES1;
    endfunction

    function automatic int des_cnt(input int idx);
        logic [7:0] d;
        int n;
        d = des_of(idx);
        n = 0;
        for (int i = 0; i < 8; i++) if (d[i]) n++;
        return n;
    endfunction

    // k-th desired channel in ascending order.
    function automatic int des_ch(input int idx, input int k);
        logic [7:0] d;
        int n;
        int r;
        d = des_of(idx);
        n = 0;
        r = 0;
        for (int i = 0; i < 8; i++)
            if (d[i]) begin
                if (n == k) r = i;
                n++;
            end
        return r;
    endfunction

    task automatic reset_models();
        for (int i = 0; i < 2; i++) begin
            hunting[i] = 1'b1;
            kpos[i]    = 0;
            err_exp[i] = 1'b0;
            rel_a[i]   = -1000;
            rel_b[i]   = -1000;
        end
        q0.delete();
        q1.delete();
    endtask

    // Completed frame: the output port serves frames in order, one channel per cycle.
    task automatic complete(input int idx, input int t);
        int   start;
        exp_t e;
        logic [7:0] d;
        d     = des_of(idx);
        start = (t + 1 > rel_a[idx] + 1) ? t + 1 : rel_a[idx] + 1;
        rel_b[idx] = rel_a[idx];
        rel_a[idx] = start + 7;
        for (int c = 0; c < 8; c++) begin
            e.at = start + c;
            e.d  = d[c] ? fd[idx][c] : 32'h0;
            e.m  = d[c] ? fm[idx][c] : 1'b0;
            e.f  = (c == 0);
            if (idx == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
    endtask

    // One sample captured at edge t; two frames still awaiting release means no room.
    task automatic model_sample(input int idx, input int t, input logic [31:0] d,
                                input logic m, input logic f);
        int ch;
        if (hunting[idx] && !f) return;
        if ((rel_a[idx] > t) && (rel_b[idx] > t)) begin
            err_exp[idx] = 1'b1;
            return;
        end
        if (hunting[idx]) begin
            hunting[idx] = 1'b0;
            kpos[idx]    = 0;
        end else if (f && kpos[idx] != 0) begin
            err_exp[idx] = 1'b1;
`ifdef CHANNEL_FRAMER_RESYNC_EN
            kpos[idx] = 0;
`endif
        end else if (!f && kpos[idx] == 0) begin
            err_exp[idx] = 1'b1;
`ifdef CHANNEL_FRAMER_RESYNC_EN
            hunting[idx] = 1'b1;
            return;
`endif
        end
        ch = des_ch(idx, kpos[idx]);
        fd[idx][ch] = d;
        fm[idx][ch] = m;
        kpos[idx]++;
        if (kpos[idx] == des_cnt(idx)) begin
            kpos[idx] = 0;
            complete(idx, t);
        end
    endtask

    task automatic mon(input int idx, input logic nd, input logic [31:0] d,
                       input logic m, input logic f);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (idx == 0) begin
            if (q0.size() > 0) begin e = q0[0]; have = 1'b1; end
        end else begin
            if (q1.size() > 0) begin e = q1[0]; have = 1'b1; end
        end
        if (have && e.at <= cyc) begin
            if (idx == 0) void'(q0.pop_front());
            else          void'(q1.pop_front());
            cmp($sformatf("out%0d nd/first/m/data", idx),
                {29'h0, nd, f, m, d}, {29'h0, (e.at == cyc), e.f, e.m, e.d});
        end else begin
            cmp($sformatf("out%0d idle out_nd", idx), 64'(nd), 64'h0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, bus0.out_nd, bus0.out_data, bus0.out_m, bus0.out_first);
            mon(1, bus1.out_nd, bus1.out_data, bus1.out_m, bus1.out_first);
        end
    end

    task automatic set_in(input logic nd, input logic [31:0] d, input logic m, input logic f);
        bus0.in_nd = nd; bus0.in_data = d; bus0.in_m = m; bus0.in_first = f;
        bus1.in_nd = nd; bus1.in_data = d; bus1.in_m = m; bus1.in_first = f;
    endtask

    task automatic send(input logic [31:0] d, input logic m, input logic f);
        @(negedge clk);
        set_in(1'b1, d, m, f);
        last_t = cyc + 1;
        model_sample(0, last_t, d, m, f);
        model_sample(1, last_t, d, m, f);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            set_in(1'b0, 32'h0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, " bus0 outs"}, {bus0.out_nd, bus0.out_first, bus0.out_m, bus0.error, bus0.out_data}, 64'h0);
        cmp({tag, " bus1 outs"}, {bus1.out_nd, bus1.out_first, bus1.out_m, bus1.error, bus1.out_data}, 64'h0);
    endtask

    task automatic check_err(input string tag);
        cmp({tag, " error full"},   64'(bus0.error), 64'(err_exp[0]));
        cmp({tag, " error sparse"}, 64'(bus1.error), 64'(err_exp[1]));
    endtask

    task automatic drain(input string tag);
        int n;
        idle(1);
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) cmp({tag, " drain timeout"}, 64'(q0.size() + q1.size()), 64'h0);
        idle(3);
        check_err(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        reset_models();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int fc;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        reset_models();
        do_reset();
        idle(2);
        check_zero("post-reset");

        // Aligned full frame 1..8.
        for (int i = 1; i <= 8; i++) send(32'(i), 1'(i), i == 1);
        drain("frame1to8");

        // Three samples carrying m=1: sparse mask fills channels 1, 2, 5.
        do_reset();
        send(32'hA, 1'b1, 1'b1);
        send(32'hB, 1'b1, 1'b0);
        send(32'hC, 1'b1, 1'b0);
        drain("sparseABC");

        // 24 back-to-back samples, three aligned frames for the full mask.
        do_reset();
        for (int i = 1; i <= 24; i++) send(32'(i), 1'(i >> 1), (i % 8) == 1);
        drain("b2b24");

        // in_first arrives on the 4th sample of a frame.
        do_reset();
        for (int i = 1; i <= 11; i++) send(32'(100 + i), 1'(i), (i == 1) || (i == 4));
        drain("misalign");

        // Asynchronous reset while channel 3 is on the outputs.
        do_reset();
        for (int i = 1; i <= 8; i++) send(32'(i * 3), 1'b1, i == 1);
        idle(1);
        n = 0;
        while (cyc < last_t + 4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmp("emit ch3 out_nd", 64'(bus0.out_nd), 64'h1);
        #2 rst = 1'b1;
        reset_models();
        #1 check_zero("async rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) send(32'(i + 50), 1'(i), i == 1);
        drain("after-async-rst");

        // Samples before any in_first are ignored.
        do_reset();
        for (int i = 0; i < 6; i++) send($urandom(), 1'($urandom_range(0, 1)), 1'b0);
        idle(20);
        check_err("prefirst");

        // Randomised bursts, mostly aligned to the full mask's frame boundary.
        do_reset();
        fc = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
            send($urandom(), 1'($urandom_range(0, 1)),
                 ((fc % 8) == 0) ^ ($urandom_range(0, 19) == 0));
            fc++;
        end
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/channel_framer.md
# channel_framer

Transmit-side counterpart of the channelizer's channel-selection stage. Accepts a sparse stream of desired-channel samples, ascending channel order, with a frame-start marker. Emits complete, aligned N-sample frames (channel 0..N-1) with undesired channels zero-filled, ready for an inverse-DIT synthesis path. Ping-pong buffering decouples bursty input from back-to-back frame output.

## Interface
- N, 8, channels per frame (power of two)
- LOGN, 3, log2(N)
- WDTH, 32, complex sample width (re/im WDTH/2 each)
- MWDTH, 1, metadata width carried per sample
- DESIRED, {N{1'b1}}, channel mask; bit c set means channel c is supplied on input; must be nonzero
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high; one clock domain
- in_data  in  WDTH  desired-channel sample
- in_nd  in  1  in_data/in_m/in_first valid this cycle
- in_m  in  MWDTH  per-sample metadata
- in_first  in  1  sample is the lowest desired channel of a frame
- out_data  out  WDTH  frame sample, channel order
- out_nd  out  1  output valid
- out_m  out  MWDTH  metadata of the sample; 0 for zero-filled channels
- out_first  out  1  high with channel 0 of each frame
- error  out  1  sticky; overflow or misalignment, cleared only by rst

## Operation
- Two N-entry buffers (A, B), each with a full flag; write pointer wsel/wch; read pointer rsel/rch.
- Write side states: HUNT (after reset), FILL.
  - HUNT: in_nd without in_first dropped silently, no error. in_nd with in_first: write at lowest desired channel, go FILL.
  - FILL: each in_nd writes wch = next desired channel above previous. Writing the highest desired channel sets full[wsel], toggles wsel, and resets wch to the lowest desired channel.
  - Undesired entries are never written; they read as zero with m=0.
- Overflow: in_nd while full[wsel] is set (both buffers occupied) drops the sample and sets error; write state unchanged.
- Misalignment: in_first with wch not at lowest desired channel, or in_first low with wch at lowest desired channel in FILL, sets error (see Configuration).
- Read side states: IDLE, EMIT.
  - IDLE: if full[rsel], go EMIT with rch=0.
  - EMIT: each cycle register channel rch of buffer rsel onto outputs, out_nd=1, out_first=(rch==0). On rch==N-1: clear full[rsel], toggle rsel; if other buffer full, continue EMIT at rch=0 (no gap), else IDLE.
- Simultaneous release and write to the same buffer on one edge: write accepted, no overflow. Emitted data comes from pre-edge contents.
- A single-bit DESIRED makes every sample a full frame; in_first required on each.

## Timing
- Reset values: out_data=0, out_nd=0, out_m=0, out_first=0, error=0; both full flags clear; wsel=rsel=A; write HUNT; read IDLE.
- Asynchronous reset mid-frame or mid-emission aborts immediately; partial frames discarded.
- Latency: last desired sample captured at edge k → channel 0 on outputs after edge k+1; channels 0..N-1 after edges k+1..k+N.
- Sustained throughput: one frame per N cycles; input may burst up to one sample/cycle; at most two frames buffered.
- out_nd low in every cycle not in EMIT; no backpressure input.

## Configuration
- CHANNEL_FRAMER_RESYNC_EN defined: misaligned in_first sets error, discards current partial frame, and writes the sample as the lowest desired channel of a new frame. in_first low at frame start sets error and returns to HUNT with the sample dropped.
- Undefined: misalignment only sets error. The sample is written at the current wch and the framing counter is unchanged.

## Test plan
- DESIRED=8'hFF, samples 1..8 on consecutive cycles, in_first on 1 → after last capture plus 1 edge, 8 consecutive outputs 1..8, out_first on 1, error=0.
- DESIRED=8'b00100110, samples A,B,C (m=1) → frame 0,A,B,0,0,C,0,0; m=0,1,1,0,0,1,0,0.
- DESIRED=8'hFF, 24 samples back-to-back → frames 1 and 2 emitted gaplessly. First sample of frame 3 dropped only if it arrives with both buffers full; error=1 then, else 0.
- DESIRED=8'hFF, in_first at 4th sample of a frame → error=1. RESYNC_EN: next frame starts at that sample. Without it: sample lands in channel 3.
- rst asserted during EMIT channel 3 → outputs zero immediately; new aligned frame after release emits correctly with error=0.
- in_nd samples before any in_first → dropped, no output, error=0.
